bcd_down_counter_2d: RTL

//  Two-digit BCD countdown timer, 00..99; down-counting counterpart of the

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_down.sv | 31 +++
 rtl/bcd_down_counter_2d.sv | 117 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } tmr_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when the nibble is a legal BCD digit (0..9).
    function automatic logic is_bcd(input logic [3:0] n);
        return (n <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 and wraps to 9.
// The borrow output is combinational, so the next digit can decrement on the same edge.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       _rst,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic       dec,
    output logic [3:0] q,
    output logic       borrow
);

    logic [3:0] r_q;

    // Digit register: a load takes precedence over a decrement; 0 wraps to 9.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
        end
    end

    assign q      = r_q;
    assign borrow = dec && (r_q == 4'd0);

endmodule

// File: rtl/bcd_down_counter_2d.sv
// Two-digit BCD countdown timer with load, start, pause and resume.
// A done pulse marks the point where the count reaches 00.
// Q uses the packed {tens,units} format.
module bcd_down_counter_2d
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned WRAP     = 0
)
(
    input  logic       clk,
    input  logic       _rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] Q,
    output logic       running,
    output logic       done,
    output logic       err
);

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    tmr_state_t    r_state;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_done;
    logic          r_err;

    logic          w_din_ok;
    logic          w_ld;
    logic          w_tick;
    logic          w_at_one;
    logic          w_units_borrow;
    logic          w_unused_tens_borrow;
    logic [3:0]    w_units;
    logic [3:0]    w_tens;

    assign w_din_ok = is_bcd(din[7:4]) && is_bcd(din[3:0]);
    assign w_ld     = load && w_din_ok;
    // Any load, including a rejected one, and any pause take priority over a tick in this cycle.
    assign w_tick   = (r_state == S_RUN) && !load && !pause && (r_presc == PRESC_LAST);
    assign w_at_one = (w_tens == 4'd0) && (w_units == 4'd1);

    bcd_digit_down u_units (
        .clk    (clk),
        ._rst   (_rst),
        .ld     (w_ld),
        .d      (din[3:0]),
        .dec    (w_tick),
        .q      (w_units),
        .borrow (w_units_borrow)
    );

    bcd_digit_down u_tens (
        .clk    (clk),
        ._rst   (_rst),
        .ld     (w_ld),
        .d      (din[7:4]),
        .dec    (w_units_borrow),
        .q      (w_tens),
        .borrow (w_unused_tens_borrow)
    );

    // Control FSM: applies load > pause > start > tick, and drives the prescaler and the registered flags.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (load) begin
                if (w_din_ok) begin
                    r_state   <= S_IDLE;
                    r_presc   <= '0;
                    r_running <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (pause) begin
                if (r_state == S_RUN) begin
                    r_state   <= S_PAUSE;
                    r_running <= 1'b0;
                end
            end else if (start && (r_state == S_IDLE || r_state == S_PAUSE)) begin
                if (Q != 8'h00) begin
                    r_state   <= S_RUN;
                    r_running <= 1'b1;
                end else begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
                if (w_tick && w_at_one) begin
                    r_done <= 1'b1;
                    if (WRAP == 0) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                    end
                end
            end
        end
    end

    assign Q       = {w_tens, w_units};
    assign running = r_running;
    assign done    = r_done;
    assign err     = r_err;

endmodule
